voice_table: RTL

- Parametrised successor to the fixed OPLL voice ROM.
- Holds NUM_BANKS constant preset banks (bank 0 = YM2413, bank 1 = VRC7, further banks optional) plus the programmable user instrument @0, backed by the eight host registers $00-$07.
- Serves two registered read ports to the operator pipeline.
- Includes a copy engine that loads any preset into the user registers.

---
 rtl/voice_table_pkg.sv | 99 +++++++++
 rtl/voice_table_user_voice_regs.sv | 28 ++
 rtl/voice_table.sv | 138 +++++++++++++
 3 files changed

// File: rtl/voice_table_pkg.sv
// OPLL voice types, preset instrument tables and user-register pack/unpack helpers.
// Presets are stored as the eight register bytes of each instrument and packed at elaboration.
package vm2413;

  typedef logic [7:0] USER_REG_TYPE;
  typedef USER_REG_TYPE [0:7] USER_REGS_TYPE;
  typedef logic [5:0] VOICE_ID_TYPE;

  typedef struct packed {
    logic       am;
    logic       pm;
    logic       eg;
    logic       kr;
    logic [3:0] ml;
    logic [1:0] kl;
    logic [5:0] tl;
    logic       wf;
    logic [2:0] fb;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
  } VOICE_TYPE;

  localparam int VOICE_SLOTS = 38;
  localparam int PATCHES     = 19;

  typedef VOICE_TYPE [0:VOICE_SLOTS-1] VOICE_BANK_TYPE;
  typedef logic [0:PATCHES-1][63:0] PATCH_TABLE_TYPE;

  // @0..@15, then the BD, HH/SD and TOM/CYM rhythm patches; register bytes $00..$07
  localparam PATCH_TABLE_TYPE YM2413_PATCHES = {
    64'h0000000000000000, 64'h71611E17D0780017, 64'h13411A0DD8F72313, 64'h13019900F2C42123,
    64'h11610E078D647027, 64'h32211E06E1760128, 64'h31221605E0710018, 64'h21611D0782811107,
    64'h33212D13B0700007, 64'h61611B0664651017, 64'h41610B1885F08107, 64'h33018311EAEF1004,
    64'h17C12407F8F82212, 64'h61500C05D2F54042, 64'h01015503E9900302, 64'h41418903F1E4C013,
    64'h0101180FDFF86A6D, 64'h01010000C8D8A768, 64'h05010000F8AA5955
  };

  localparam PATCH_TABLE_TYPE VRC7_PATCHES = {
    64'h0000000000000000, 64'h03210506E8814227, 64'h1341140DD8F62312, 64'h11110808FAB22012,
    64'h31610C07A8646127, 64'h32211E06E1760128, 64'h02010600A3E2F4F4, 64'h21611D0782811107,
    64'h23212217A2720117, 64'h3511250040737201, 64'hB5010F0FA8A55102, 64'h17C12407F8F82212,
    64'h7123110665741816, 64'h0102D305C9950302, 64'h61630C0094C033F6, 64'h21720D00C1D55606,
    64'h0101180FDFF86A6D, 64'h01010000C8D8A768, 64'h05010000F8AA5955
  };

  function automatic VOICE_TYPE pack_user_m(USER_REGS_TYPE ur);
    VOICE_TYPE v;
    v = '0;
    {v.am, v.pm, v.eg, v.kr, v.ml} = ur[0];
    {v.kl, v.tl}                   = ur[2];
    v.wf                           = ur[3][3];
    v.fb                           = ur[3][2:0];
    {v.ar, v.dr}                   = ur[4];
    {v.sl, v.rr}                   = ur[6];
    return v;
  endfunction

  // The carrier has no TL or FB of its own; both stay zero.
  function automatic VOICE_TYPE pack_user_c(USER_REGS_TYPE ur);
    VOICE_TYPE v;
    v = '0;
    {v.am, v.pm, v.eg, v.kr, v.ml} = ur[1];
    v.kl                           = ur[3][7:6];
    v.wf                           = ur[3][4];
    {v.ar, v.dr}                   = ur[5];
    {v.sl, v.rr}                   = ur[7];
    return v;
  endfunction

  function automatic USER_REG_TYPE unpack_reg(VOICE_TYPE m, VOICE_TYPE c, logic [2:0] idx);
    USER_REG_TYPE r;
    case (idx)
      3'd0:    r = {m.am, m.pm, m.eg, m.kr, m.ml};
      3'd1:    r = {c.am, c.pm, c.eg, c.kr, c.ml};
      3'd2:    r = {m.kl, m.tl};
      3'd3:    r = {c.kl, 1'b0, c.wf, m.wf, m.fb};
      3'd4:    r = {m.ar, m.dr};
      3'd5:    r = {c.ar, c.dr};
      3'd6:    r = {m.sl, m.rr};
      default: r = {c.sl, c.rr};
    endcase
    return r;
  endfunction

  function automatic VOICE_BANK_TYPE build_bank(PATCH_TABLE_TYPE p);
    VOICE_BANK_TYPE b;
    for (int i = 0; i < PATCHES; i++) begin
      b[2*i]   = pack_user_m(USER_REGS_TYPE'(p[i]));
      b[2*i+1] = pack_user_c(USER_REGS_TYPE'(p[i]));
    end
    return b;
  endfunction

  localparam VOICE_BANK_TYPE YM2413_VOICES = build_bank(YM2413_PATCHES);
  localparam VOICE_BANK_TYPE VRC7_VOICES   = build_bank(VRC7_PATCHES);

endpackage

// File: rtl/voice_table_user_voice_regs.sv
// User instrument @0: eight host registers with a single write port and packed M/C voice views.
// Writes land at the clock edge; the packed outputs follow the registers combinationally.
module user_voice_regs
  import vm2413::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_we,
  input  logic [2:0]   i_waddr,
  input  USER_REG_TYPE i_wdata,
  output VOICE_TYPE    o_user_m,
  output VOICE_TYPE    o_user_c
);

  USER_REGS_TYPE r_ur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ur <= '0;
    end else if (i_we) begin
      r_ur[i_waddr] <= i_wdata;
    end
  end

  assign o_user_m = pack_user_m(r_ur);
  assign o_user_c = pack_user_c(r_ur);

endmodule

// File: rtl/voice_table.sv
// Voice store: preset banks plus user voice @0, two registered read ports (1-cycle latency),
// and an 8-cycle copy engine that loads a preset into the user registers.
module voice_table
  import vm2413::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int NUM_SLOTS = 38
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BANK_W-1:0] bank_sel,
  input  VOICE_ID_TYPE      rd_addr_a,
  output VOICE_TYPE         rd_data_a,
  input  VOICE_ID_TYPE      rd_addr_b,
  output VOICE_TYPE         rd_data_b,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_drop,
  input  logic              load_req,
  input  logic [3:0]        load_voice,
  input  logic [BANK_W-1:0] load_bank,
  output logic              load_busy,
  output logic              load_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [3:0]        r_voice;
  logic [BANK_W-1:0] r_bank;
  logic              r_wr_drop;
  VOICE_TYPE         r_rd_a, r_rd_b;

  logic              w_latch, w_we, w_busy, w_done;
  logic [2:0]        w_waddr;
  USER_REG_TYPE      w_wdata;
  VOICE_TYPE         w_user_m, w_user_c, w_src_m, w_src_c;

  // Raw bank lookup; slots 0/1 hold the all-zero @0 preset, used as the copy source for voice 0.
  function automatic VOICE_TYPE f_preset(logic [BANK_W-1:0] bank, VOICE_ID_TYPE addr);
    VOICE_TYPE v;
    v = '0;
    if (int'(bank) < NUM_BANKS && int'(addr) < NUM_SLOTS) begin
      if (bank == BANK_W'(0))      v = YM2413_VOICES[addr];
      else if (bank == BANK_W'(1)) v = VRC7_VOICES[addr];
    end
    return v;
  endfunction

  function automatic VOICE_TYPE f_read(logic [BANK_W-1:0] bank, VOICE_ID_TYPE addr,
                                       VOICE_TYPE user_m, VOICE_TYPE user_c);
    VOICE_TYPE v;
    if (addr == VOICE_ID_TYPE'(0))      v = user_m;
    else if (addr == VOICE_ID_TYPE'(1)) v = user_c;
    else                                v = f_preset(bank, addr);
    return v;
  endfunction

  assign w_src_m = f_preset(r_bank, {1'b0, r_voice, 1'b0});
  assign w_src_c = f_preset(r_bank, {1'b0, r_voice, 1'b1});

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_we        = 1'b0;
    w_waddr     = wr_addr;
    w_wdata     = wr_data;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_we = wr_en;
        if (load_req) begin
          w_latch     = 1'b1;
          w_idx_nxt   = 3'd0;
          w_state_nxt = ST_COPY;
        end
      end
      ST_COPY: begin
        w_busy    = 1'b1;
        w_we      = 1'b1;
        w_waddr   = r_idx;
        w_wdata   = unpack_reg(w_src_m, w_src_c, r_idx);
        w_idx_nxt = r_idx + 3'd1;
        if (r_idx == 3'd7) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_voice   <= 4'd0;
      r_bank    <= '0;
      r_wr_drop <= 1'b0;
      r_rd_a    <= '0;
      r_rd_b    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wr_drop <= wr_en & w_busy;
      r_rd_a    <= f_read(bank_sel, rd_addr_a, w_user_m, w_user_c);
      r_rd_b    <= f_read(bank_sel, rd_addr_b, w_user_m, w_user_c);
      if (w_latch) begin
        r_voice <= load_voice;
        r_bank  <= load_bank;
      end
    end
  end

  user_voice_regs u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .o_user_m (w_user_m),
    .o_user_c (w_user_c)
  );

  assign rd_data_a = r_rd_a;
  assign rd_data_b = r_rd_b;
  assign wr_drop   = r_wr_drop;
  assign load_busy = w_busy;
  assign load_done = w_done;

endmodule
